// File: rtl/cpu_pkg.sv
// Shared CPU types and widths used by the fetch stage and the decode datapath.
// Fetch entries pair an instruction with the address it was read from.
package cpu_pkg;

  localparam int ADDR_W  = 6;
  localparam int INST_W  = 16;
  localparam int ENTRY_W = INST_W + ADDR_W;

  typedef logic [ADDR_W-1:0] pc_t;
  typedef logic [INST_W-1:0] inst_t;

  typedef struct packed {
    inst_t inst;
    pc_t   pc;
  } fetch_entry_t;

  // Sequential successor; wraps from the top of program memory back to 0.
  function automatic pc_t next_pc(input pc_t pc);
    return pc + pc_t'(1);
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// Prefetch FIFO holding {inst, pc} entries between fetch and decode.
// Flush has priority over push and pop; a push when full or a pop when empty is dropped.
module inst_fifo
  import cpu_pkg::*;
#(
  parameter int WIDTH = ENTRY_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign do_push  = push && !flush && !full;
  assign do_pop   = pop && !flush && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, issues reads to a one-cycle program memory,
// buffers fetched words in a prefetch FIFO and hands them to decode over valid/ready.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              dec_ready
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  pc_t              fetch_pc;
  logic             inflight;
  pc_t              inflight_pc;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   credit_used;
  logic             has_credit;
  logic             fifo_empty;
  logic             fifo_push;
  fetch_entry_t     push_entry;
  fetch_entry_t     head_entry;
  logic [ENTRY_W-1:0] head_bits;

  // A pop in the same cycle is not credited, so the buffer plus the outstanding
  // read can never exceed DEPTH and the landing word always has a slot.
  assign credit_used = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
  assign has_credit  = credit_used < (CNT_W + 1)'(DEPTH);
  assign imem_req    = !reset && !redirect && has_credit;
  assign imem_addr   = fetch_pc;

  assign fifo_push       = inflight && !redirect;
  assign push_entry.inst = imem_rdata;
  assign push_entry.pc   = inflight_pc;
  assign head_entry      = fetch_entry_t'(head_bits);

  assign inst_valid = !fifo_empty;
  assign inst       = inst_valid ? head_entry.inst : '0;
  assign inst_pc    = inst_valid ? head_entry.pc   : '0;

  // Redirect wins over everything: the outstanding read is abandoned and fetch
  // restarts at the branch target on the next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect) begin
      fetch_pc    <= redirect_pc;
      inflight    <= 1'b0;
    end else if (imem_req) begin
      inflight    <= 1'b1;
      inflight_pc <= fetch_pc;
      fetch_pc    <= next_pc(fetch_pc);
    end else begin
      inflight    <= 1'b0;
    end
  end

  inst_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (dec_ready),
    .pop_data  (head_bits),
    .empty     (fifo_empty),
    .count     (count)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a one-cycle registered program memory
// holding word[i] = 0x1000 + i.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [5:0]  imem_addr;
  logic [15:0] imem_rdata = 16'h0000;
  logic        redirect;
  logic [5:0]  redirect_pc;
  logic        inst_valid;
  logic [15:0] inst;
  logic [5:0]  inst_pc;
  logic        dec_ready;

  int checks = 0;
  int errors = 0;

  inst_fetch #(.DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .dec_ready   (dec_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_req) begin
      imem_rdata <= 16'h1000 + {10'b0, imem_addr};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic ereq, input logic [5:0] eaddr,
                             input logic evalid, input logic [15:0] einst, input logic [5:0] epc);
    #1;
    check({tag, ".req"},   {31'b0, imem_req},   {31'b0, ereq});
    check({tag, ".addr"},  {26'b0, imem_addr},  {26'b0, eaddr});
    check({tag, ".valid"}, {31'b0, inst_valid}, {31'b0, evalid});
    check({tag, ".inst"},  {16'b0, inst},       {16'b0, einst});
    check({tag, ".pc"},    {26'b0, inst_pc},    {26'b0, epc});
  endtask

  task automatic step(input string tag, input logic ereq, input logic [5:0] eaddr,
                      input logic evalid, input logic [15:0] einst, input logic [5:0] epc);
    check_state(tag, ereq, eaddr, evalid, einst, epc);
    @(posedge clk);
    #1;
  endtask

  // Asserts reset for one clock edge, checking outputs clear immediately.
  task automatic pulse_reset(input string tag, input logic ready_after);
    reset = 1'b1;
    check_state(tag, 1'b0, 6'd0, 1'b0, 16'h0, 6'd0);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    redirect  = 1'b0;
    dec_ready = ready_after;
  endtask

  initial begin
    reset       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 6'd0;
    dec_ready   = 1'b1;
    #2;

    // Reset release with decode always ready: one instruction per cycle.
    pulse_reset("rst0", 1'b1);
    step("t1c0", 1'b1, 6'd0, 1'b0, 16'h0, 6'd0);
    step("t1c1", 1'b1, 6'd1, 1'b0, 16'h0, 6'd0);
    for (int k = 2; k < 8; k++) begin
      step($sformatf("t1c%0d", k), 1'b1, 6'(k), 1'b1, 16'h1000 + 16'(k - 2), 6'(k - 2));
    end

    // Decode stalled from release: exactly four requests, then back-pressure.
    pulse_reset("rst1", 1'b0);
    step("t2c0", 1'b1, 6'd0, 1'b0, 16'h0,    6'd0);
    step("t2c1", 1'b1, 6'd1, 1'b0, 16'h0,    6'd0);
    step("t2c2", 1'b1, 6'd2, 1'b1, 16'h1000, 6'd0);
    step("t2c3", 1'b1, 6'd3, 1'b1, 16'h1000, 6'd0);
    step("t2c4", 1'b0, 6'd4, 1'b1, 16'h1000, 6'd0);
    step("t2c5", 1'b0, 6'd4, 1'b1, 16'h1000, 6'd0);
    dec_ready = 1'b1;
    step("t2c6", 1'b0, 6'd4, 1'b1, 16'h1000, 6'd0);
    step("t2c7", 1'b1, 6'd4, 1'b1, 16'h1001, 6'd1);
    step("t2c8", 1'b1, 6'd5, 1'b1, 16'h1002, 6'd2);
    step("t2c9", 1'b1, 6'd6, 1'b1, 16'h1003, 6'd3);
    step("t2c10", 1'b1, 6'd7, 1'b1, 16'h1004, 6'd4);

    // Redirect to 0x20 with three buffered and one in flight.
    pulse_reset("rst2", 1'b0);
    step("t3c0", 1'b1, 6'd0, 1'b0, 16'h0,    6'd0);
    step("t3c1", 1'b1, 6'd1, 1'b0, 16'h0,    6'd0);
    step("t3c2", 1'b1, 6'd2, 1'b1, 16'h1000, 6'd0);
    step("t3c3", 1'b1, 6'd3, 1'b1, 16'h1000, 6'd0);
    redirect = 1'b1; redirect_pc = 6'h20;
    step("t3c4", 1'b0, 6'd4, 1'b1, 16'h1000, 6'd0);
    redirect = 1'b0; dec_ready = 1'b1;
    step("t3c5", 1'b1, 6'h20, 1'b0, 16'h0,    6'd0);
    step("t3c6", 1'b1, 6'h21, 1'b0, 16'h0,    6'd0);
    step("t3c7", 1'b1, 6'h22, 1'b1, 16'h1020, 6'h20);

    // Redirect to 62: delivered addresses wrap 62, 63, 0, 1.
    redirect = 1'b1; redirect_pc = 6'd62;
    step("t4c0", 1'b0, 6'h23, 1'b1, 16'h1021, 6'h21);
    redirect = 1'b0;
    step("t4c1", 1'b1, 6'd62, 1'b0, 16'h0,    6'd0);
    step("t4c2", 1'b1, 6'd63, 1'b0, 16'h0,    6'd0);
    step("t4c3", 1'b1, 6'd0,  1'b1, 16'h103E, 6'd62);
    step("t4c4", 1'b1, 6'd1,  1'b1, 16'h103F, 6'd63);
    step("t4c5", 1'b1, 6'd2,  1'b1, 16'h1000, 6'd0);
    step("t4c6", 1'b1, 6'd3,  1'b1, 16'h1001, 6'd1);

    // Redirect with push and pop at count=2, then back-to-back redirects 5 then 9.
    pulse_reset("rst3", 1'b0);
    step("t5c0", 1'b1, 6'd0, 1'b0, 16'h0,    6'd0);
    step("t5c1", 1'b1, 6'd1, 1'b0, 16'h0,    6'd0);
    step("t5c2", 1'b1, 6'd2, 1'b1, 16'h1000, 6'd0);
    dec_ready = 1'b1; redirect = 1'b1; redirect_pc = 6'd5;
    step("t5c3", 1'b0, 6'd3, 1'b1, 16'h1000, 6'd0);
    redirect_pc = 6'd9;
    step("t5c4", 1'b0, 6'd5, 1'b0, 16'h0,    6'd0);
    redirect = 1'b0;
    step("t5c5", 1'b1, 6'd9,  1'b0, 16'h0,    6'd0);
    step("t5c6", 1'b1, 6'd10, 1'b0, 16'h0,    6'd0);
    dec_ready = 1'b0;
    step("t5c7", 1'b1, 6'd11, 1'b1, 16'h1009, 6'd9);
    step("t5c8", 1'b1, 6'd12, 1'b1, 16'h1009, 6'd9);
    check_state("t5c9", 1'b0, 6'd13, 1'b1, 16'h1009, 6'd9);

    // Mid-stream reset with count=3 and a read outstanding.
    pulse_reset("rst4", 1'b1);
    step("t6c0", 1'b1, 6'd0, 1'b0, 16'h0,    6'd0);
    step("t6c1", 1'b1, 6'd1, 1'b0, 16'h0,    6'd0);
    step("t6c2", 1'b1, 6'd2, 1'b1, 16'h1000, 6'd0);
    step("t6c3", 1'b1, 6'd3, 1'b1, 16'h1001, 6'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
